// File: rtl/rr_arbiter_pkg.sv
// Shared types for the round-robin arbiter: FSM state encoding.
package rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin selector: lowest set request at or above ptr,
// falling back to the lowest set request overall when none qualifies.
module rr_pick #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]         req,
    input  logic [$clog2(WIDTH)-1:0] ptr,
    output logic [WIDTH-1:0]         pick,
    output logic [$clog2(WIDTH)-1:0] pick_idx,
    output logic                     pick_val
);
    localparam int IW = $clog2(WIDTH);

    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] masked;
    logic [WIDTH-1:0] sel;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
        assign mask[gi] = (IW'(gi) >= ptr);
    end

    assign masked = req & mask;
    assign sel    = (masked != '0) ? masked : req;

    // Two's-complement trick isolates the lowest set bit.
    assign pick     = sel & (~sel + WIDTH'(1));
    assign pick_val = |req;

    always_comb begin
        pick_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (sel[i]) begin
                pick_idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: registers a one-hot grant and holds it until done_i,
// then advances the priority pointer past the last winner.
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [WIDTH-1:0]         req_i,
    input  logic                     done_i,
    output logic [WIDTH-1:0]         gnt_o,
    output logic                     gnt_val_o,
    output logic [$clog2(WIDTH)-1:0] gnt_idx_o
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    state_t           state_q,   state_d;
    logic [IW-1:0]    ptr_q,     ptr_d;
    logic [WIDTH-1:0] gnt_q,     gnt_d;
    logic             gnt_val_q, gnt_val_d;
    logic [IW-1:0]    gnt_idx_q, gnt_idx_d;

    logic [WIDTH-1:0] pick;
    logic [IW-1:0]    pick_idx;
    logic             pick_val;

    rr_pick #(
        .WIDTH(WIDTH)
    ) u_pick (
        .req     (req_i),
        .ptr     (ptr_q),
        .pick    (pick),
        .pick_idx(pick_idx),
        .pick_val(pick_val)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            gnt_val_q <= 1'b0;
            gnt_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            gnt_val_q <= gnt_val_d;
            gnt_idx_q <= gnt_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        gnt_val_d = gnt_val_q;
        gnt_idx_d = gnt_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_val) begin
                    gnt_d     = pick;
                    gnt_idx_d = pick_idx;
                    gnt_val_d = 1'b1;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Grant is frozen until completion; requests are not looked at here.
                if (done_i) begin
                    gnt_d     = '0;
                    gnt_idx_d = '0;
                    gnt_val_d = 1'b0;
                    ptr_d     = (gnt_idx_q == LAST_IDX) ? '0 : gnt_idx_q + IW'(1);
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign gnt_o     = gnt_q;
    assign gnt_val_o = gnt_val_q;
    assign gnt_idx_o = gnt_idx_q;

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Round-robin arbiter sharing one downstream resource between `WIDTH` requesters. It registers a one-hot grant and holds it until the resource signals completion. The rotating priority pointer gives fair service. The block sits in front of any shared datapath whose users present a request vector, such as the bit vectors resolved by the priority encoders. Selection reuses the same right-most-bit (lowest-index) priority scheme, applied to a pointer-masked request vector.

## Interface
- `WIDTH`, default 4: number of requesters; legal range ≥ 2.
- `clk_i`  in  1  single clock; all state updates on rising edge.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `req_i`  in  `WIDTH`  per-requester request level; bit i = requester i.
- `done_i`  in  1  single-cycle pulse from the shared resource ending the current transaction.
- `gnt_o`  out  `WIDTH`  registered one-hot grant; all-zero when idle.
- `gnt_val_o`  out  1  high while any grant is held; equals `|gnt_o`.
- `gnt_idx_o`  out  `$clog2(WIDTH)`  binary index of the granted requester; valid only while `gnt_val_o` is high.

## Operation
- State machine, two states:
  - IDLE: no grant outstanding.
    - If `req_i != 0`, the winner is the lowest set index at or above `ptr`.
    - If there is none, the winner is the lowest set index overall (wrap).
    - On the next edge, register `gnt_o`, `gnt_idx_o` and `gnt_val_o`, then go to BUSY.
    - If `req_i == 0`, remain in IDLE.
  - BUSY: the grant is frozen, whatever `req_i` does.
    - On an edge with `done_i` = 1: clear `gnt_o`, `gnt_val_o` and `gnt_idx_o`.
    - On the same edge, set `ptr` ← `gnt_idx_o + 1`, wrapping to 0 when it equals `WIDTH`.
    - Then go to IDLE.
- `ptr` is a `$clog2(WIDTH)`-bit register; modulo `WIDTH` arithmetic applies for non-power-of-2 `WIDTH`.
- A requester that deasserts `req_i` while granted keeps the grant until `done_i`. Ownership ends only on completion.
- `done_i` in IDLE is ignored. It has no effect on state or `ptr`.
- Simultaneous `done_i` and new requests: the grant is released first, and arbitration happens in the following IDLE cycle.
- Reset values: state IDLE, `ptr` = 0, `gnt_o` = 0, `gnt_val_o` = 0, `gnt_idx_o` = 0.
- Reset asserted mid-BUSY clears all outputs immediately (asynchronously), without waiting for a clock edge.

## Timing
- Request to grant: `req_i` sampled at edge N in IDLE → `gnt_o` visible after edge N (one-cycle latency).
- Grant to release: `done_i` high at edge M → `gnt_o` = 0 after edge M.
- Back-to-back grants: minimum one IDLE cycle between consecutive grants. The peak rate is one grant per 2 cycles plus the transaction length.
- All outputs come straight from flops, with no combinational path from inputs to outputs.
- Reset release: the first arbitration happens on the first edge after `rst_n_i` deasserts.

## Structure
- Package `rr_arbiter_pkg` holds the `state_t` enum (`ST_IDLE`, `ST_BUSY`).
- Sub-module `rr_pick` is combinational and is instantiated once.
  - Inputs: `req`, `ptr`. Outputs: one-hot `pick`, binary `pick_idx`, `pick_val`.
  - Internals: masked vector = `req` & (bits ≥ `ptr`); lowest-set-bit select on the masked vector; fallback to lowest-set-bit of unmasked `req` if the masked vector is zero.
- The top level holds the FSM, the `ptr` register and the output registers.

## Test plan
1. Reset:
   - Stimulus: `rst_n_i` = 0 with `req_i` = 4'b1111, then release with `req_i` = 0 for 3 cycles.
   - Response: `gnt_o` = 0, `gnt_val_o` = 0 throughout, state IDLE.
2. Basic grant and hold:
   - Stimulus: `ptr` = 0, `req_i` = 4'b1010; hold `done_i` low 5 cycles, then pulse `done_i`.
   - Response: `gnt_o` = 4'b0010, `gnt_idx_o` = 1 one cycle after the request, held for 5 cycles. After the pulse, `gnt_o` = 0 and `ptr` = 2.
3. Fairness:
   - Stimulus: `req_i` = 4'b1111 constant; pulse `done_i` 2 cycles after each grant.
   - Response: grant sequence 0001, 0010, 0100, 1000, 0001, with one idle cycle between grants.
4. Wrap-around:
   - Stimulus: after a grant to idx 2 (`ptr` = 3), apply `req_i` = 4'b0011.
   - Response: `gnt_o` = 4'b0001. With `req_i` = 4'b1011 instead, `gnt_o` = 4'b1000.
5. Held ownership and ignored `done_i`:
   - Stimulus: granted requester drops `req_i` mid-BUSY; separately, pulse `done_i` while IDLE.
   - Response: the grant persists until `done_i`. The IDLE `done_i` leaves `ptr` and outputs unchanged.
6. Reset mid-transaction:
   - Stimulus: assert `rst_n_i` between edges while BUSY with `gnt_o` = 4'b0100.
   - Response: `gnt_o` = 0 and `gnt_val_o` = 0 before the next edge. After release with `req_i` = 4'b0100, the grant goes to idx 2 from `ptr` = 0.
